// File: rtl/rx_stream_pipe_packer.sv
// rx_stream_pipe_packer: packs a byte stream into little-endian 16-bit words and buffers them
// in a block-RAM FIFO drained by an okPipeOut endpoint, publishing the word count on an okWireOut.
module rx_stream_pipe_packer #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic        ti_clk,
    input  logic        ti_rst,
    input  logic        s_rx_valid,
    input  logic [7:0]  s_rx_data,
    input  logic        s_rx_flush,
    output logic [15:0] ti_out_available,
    input  logic        ti_out_data_en,
    output logic [15:0] ti_out_data,
    output logic        overflow,
    output logic        underflow
);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    typedef enum logic {EMPTY, HALF} state_t;
    state_t state, state_next;
    logic [7:0] lo_byte;
    logic push, full, empty, do_pop, do_push;
    logic [15:0] word;
    logic [MEM_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [MEM_ADDR_WIDTH:0] count;
    logic [15:0] mem [DEPTH];
    always_ff @(posedge ti_clk) begin
        if (ti_rst) begin
            state   <= EMPTY;
            lo_byte <= 8'h00;
        end else begin
            state <= state_next;
            if (state == EMPTY && s_rx_valid) lo_byte <= s_rx_data;
        end
    end
    always_comb begin
        state_next = (state == EMPTY) ? ((s_rx_valid && !s_rx_flush) ? HALF : EMPTY)
                                      : ((s_rx_valid || s_rx_flush) ? EMPTY : HALF);
    end
    // A flush in EMPTY only matters when it arrives alongside a byte.
    always_comb begin
        push = (state == HALF) ? (s_rx_valid || s_rx_flush) : (s_rx_valid && s_rx_flush);
        word = (state == HALF && s_rx_valid) ? {s_rx_data, lo_byte}
                                             : {8'h00, (state == HALF) ? lo_byte : s_rx_data};
    end
    always_comb begin
        full    = count == (MEM_ADDR_WIDTH+1)'(DEPTH);
        empty   = count == '0;
        do_pop  = ti_out_data_en && !empty;
        do_push = push && (!full || do_pop);
    end
    always_ff @(posedge ti_clk) begin
        if (do_push) mem[wr_ptr] <= word;
    end
    always_ff @(posedge ti_clk) begin
        if (ti_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ti_out_data <= 16'h0000;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + MEM_ADDR_WIDTH'(1);
            if (do_pop) begin
                rd_ptr      <= rd_ptr + MEM_ADDR_WIDTH'(1);
                ti_out_data <= mem[rd_ptr];
            end
            if (do_push && !do_pop) count <= count + (MEM_ADDR_WIDTH+1)'(1);
            else if (do_pop && !do_push) count <= count - (MEM_ADDR_WIDTH+1)'(1);
            if (push && !do_push) overflow <= 1'b1;
            if (ti_out_data_en && empty) underflow <= 1'b1;
        end
    end
    assign ti_out_available = 16'(count);
endmodule

// File: tb/tb_rx_stream_pipe_packer.sv
// tb_rx_stream_pipe_packer: randomized and directed stimulus against a queue-based word FIFO model,
// with a monitor that checks count, popped data and sticky flags after every clock edge.
module tb_rx_stream_pipe_packer;
    localparam int AW = 2;
    localparam int DEPTH = 1 << AW;
    logic        ti_clk = 1'b0;
    logic        ti_rst = 1'b1;
    logic        s_rx_valid = 1'b0;
    logic [7:0]  s_rx_data = 8'h00;
    logic        s_rx_flush = 1'b0;
    logic [15:0] ti_out_available;
    logic        ti_out_data_en = 1'b0;
    logic [15:0] ti_out_data;
    logic        overflow, underflow;

    rx_stream_pipe_packer #(.MEM_ADDR_WIDTH(AW)) dut (
        .ti_clk(ti_clk), .ti_rst(ti_rst), .s_rx_valid(s_rx_valid), .s_rx_data(s_rx_data),
        .s_rx_flush(s_rx_flush), .ti_out_available(ti_out_available), .ti_out_data_en(ti_out_data_en),
        .ti_out_data(ti_out_data), .overflow(overflow), .underflow(underflow)
    );

    always #5 ti_clk = ~ti_clk;

    int tests = 0;
    int fails = 0;
    bit armed = 0;
    bit popped = 0;
    logic [15:0] mq[$];
    logic [15:0] exp_q[$];
    logic [15:0] last_data = 16'h0000;
    bit m_half = 0;
    logic [7:0] m_lo = 8'h00;
    bit m_over = 0;
    bit m_under = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs and advances the model by the effect of the coming edge.
    task automatic drive(input bit v, input logic [7:0] d, input bit f, input bit e);
        int n;
        bit have;
        logic [15:0] w;
        @(negedge ti_clk);
        #1;
        ti_rst = 0; s_rx_valid = v; s_rx_data = d; s_rx_flush = f; ti_out_data_en = e;
        n = mq.size();
        popped = e && n > 0;
        if (e && n == 0) m_under = 1;
        if (popped) exp_q.push_back(mq.pop_front());
        have = 0;
        w = 16'h0000;
        if (m_half) begin
            if (v) begin w = {d, m_lo}; have = 1; m_half = 0; end
            else if (f) begin w = {8'h00, m_lo}; have = 1; m_half = 0; end
        end else if (v) begin
            if (f) begin w = {8'h00, d}; have = 1; end
            else begin m_lo = d; m_half = 1; end
        end
        if (have) begin
            if (n < DEPTH || popped) mq.push_back(w);
            else m_over = 1;
        end
    endtask

    task automatic rst_cycle();
        @(negedge ti_clk);
        #1;
        ti_rst = 1; s_rx_valid = 0; s_rx_data = 8'h00; s_rx_flush = 0; ti_out_data_en = 0;
        armed = 1;
        popped = 0;
        mq.delete();
        exp_q.delete();
        m_half = 0; m_over = 0; m_under = 0;
    endtask

    task automatic settle();
        @(posedge ti_clk);
        #2;
    endtask

    always @(posedge ti_clk) begin
        #1;
        if (armed) begin
            if (ti_rst) last_data = 16'h0000;
            else if (popped) last_data = exp_q.pop_front();
            chk("available", ti_out_available, 16'(mq.size()));
            chk("data", ti_out_data, last_data);
            chk("overflow", 16'(overflow), 16'(m_over));
            chk("underflow", 16'(underflow), 16'(m_under));
        end
    end

    initial begin
        rst_cycle();
        rst_cycle();
        drive(1, 8'h11, 0, 0);
        drive(1, 8'h22, 0, 0);
        drive(1, 8'h33, 0, 0);
        drive(1, 8'h44, 0, 0);
        drive(0, 8'h00, 0, 1);
        settle();
        chk("first_pop", ti_out_data, 16'h2211);
        drive(0, 8'h00, 0, 1);
        settle();
        chk("second_pop", ti_out_data, 16'h4433);
        chk("drained", ti_out_available, 16'd0);
        drive(1, 8'hAB, 0, 0);
        drive(0, 8'h00, 1, 0);
        drive(1, 8'hCD, 1, 0);
        drive(0, 8'h00, 1, 0);
        settle();
        chk("flush_count", ti_out_available, 16'd2);
        drive(0, 8'h00, 0, 1);
        settle();
        chk("flush_odd", ti_out_data, 16'h00AB);
        drive(0, 8'h00, 0, 1);
        settle();
        chk("flush_same", ti_out_data, 16'h00CD);
        for (int i = 1; i <= 10; i++) drive(1, 8'(i), 0, 0);
        settle();
        chk("sat_count", ti_out_available, 16'd4);
        chk("sat_overflow", 16'(overflow), 16'd1);
        drive(1, 8'hB1, 0, 0);
        drive(1, 8'hB2, 0, 1);
        settle();
        chk("full_pushpop_count", ti_out_available, 16'd4);
        chk("full_pushpop_data", ti_out_data, 16'h0201);
        for (int i = 0; i < 4; i++) drive(0, 8'h00, 0, 1);
        settle();
        chk("full_last", ti_out_data, 16'hB2B1);
        drive(0, 8'h00, 0, 1);
        settle();
        chk("underflow", 16'(underflow), 16'd1);
        chk("underflow_hold", ti_out_data, 16'hB2B1);
        drive(1, 8'h5A, 0, 0);
        drive(1, 8'hA5, 0, 0);
        drive(0, 8'h00, 0, 1);
        settle();
        chk("after_underflow", ti_out_data, 16'hA55A);
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 6; k++) drive(1, 8'(r * 6 + k), 0, 0);
            for (int k = 0; k < 3; k++) drive(0, 8'h00, 0, 1);
        end
        settle();
        chk("wrap_last", ti_out_data, {8'd59, 8'd58});
        chk("wrap_count", ti_out_available, 16'd0);
        for (int k = 0; k < 5; k++) drive(1, 8'hE0 + 8'(k), 0, 0);
        rst_cycle();
        settle();
        chk("midrst_count", ti_out_available, 16'd0);
        chk("midrst_flags", {14'd0, overflow, underflow}, 16'd0);
        drive(1, 8'h34, 0, 0);
        drive(1, 8'h12, 0, 0);
        drive(0, 8'h00, 0, 1);
        settle();
        chk("midrst_pair", ti_out_data, 16'h1234);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) rst_cycle();
            else drive($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) == 0,
                       $urandom_range(0, 9) < 4);
        end
        for (int i = 0; i < 6; i++) drive(0, 8'h00, 0, 1);
        settle();
        armed = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rx_stream_pipe_packer.md
Name: rx_stream_pipe_packer

Overview:
Receive-side counterpart to the project's byte-stream output (s_rx_valid/s_rx_data). It accepts a valid-qualified byte stream, packs byte pairs into 16-bit words and buffers them in an internal RAM FIFO. A host okPipeOut endpoint drains the FIFO, and an okWireOut endpoint publishes the available word count. Everything runs in the ti_clk domain.

Parameters:
MEM_ADDR_WIDTH, 10, log2 of FIFO depth in 16-bit words (depth = 2^MEM_ADDR_WIDTH, range 2..15).

Ports:
ti_clk  input  1  sole clock; okHost interface clock.
ti_rst  input  1  synchronous, active-high reset; sampled on ti_clk rising edge.
s_rx_valid  input  1  byte strobe; one byte accepted per asserted cycle; no backpressure.
s_rx_data  input  8  byte payload; qualified by s_rx_valid.
s_rx_flush  input  1  single-cycle pulse; pushes a pending odd byte as a zero-padded word.
ti_out_available  output  16  count of complete words in FIFO, zero-extended.
ti_out_data_en  input  1  okPipeOut ep_read; pops one word.
ti_out_data  output  16  okPipeOut ep_datain.
overflow  output  1  sticky; a word was dropped because the FIFO was full.
underflow  output  1  sticky; ti_out_data_en was asserted while the FIFO was empty.

Behaviour:
- Reset. While ti_rst is high at a clock edge:
  - Read/write pointers, word count and packer state are cleared.
  - ti_out_available=0, ti_out_data=16'h0000, overflow=0, underflow=0.
  - RAM contents are don't-care.
  - A half-packed byte is discarded.
  - Inputs are ignored during reset.
- Packer FSM, states EMPTY and HALF (HALF holds lo_byte):
  - EMPTY + s_rx_valid: latch lo_byte, go to HALF.
  - HALF + s_rx_valid: push word {s_rx_data, lo_byte}, go to EMPTY. The first byte received is the low byte (little-endian).
  - HALF + s_rx_flush, no valid: push {8'h00, lo_byte}, go to EMPTY.
  - EMPTY + s_rx_valid + s_rx_flush: push {8'h00, s_rx_data}, stay in EMPTY.
  - HALF + s_rx_valid + s_rx_flush: the byte completes the word normally; flush has no further effect.
  - EMPTY + s_rx_flush alone: no operation.
- Push. A word is written to RAM[wr_ptr] at the edge ending the cycle it is formed. wr_ptr increments modulo depth.
- Pop:
  - ti_out_data_en in cycle N with count>0: ti_out_data = RAM[rd_ptr] from cycle N+1, and rd_ptr increments. This gives a 1-cycle read latency, matching okPipeOut's sample timing.
  - ti_out_data holds its value until the next successful pop.
- Full and empty, evaluated on the registered count:
  - Push with count==depth and no simultaneous pop: word dropped, overflow set. Pointers, count and data are unchanged.
  - Push and pop in the same cycle at count==depth: both succeed; count is unchanged.
  - Pop with count==0: ignored. ti_out_data holds, underflow is set. A push in the same cycle still succeeds.
- Count: registered. Push-only gives +1 and pop-only gives -1 on the next edge. ti_out_available reflects a written word 1 cycle after the push edge. Range is 0..depth; width MEM_ADDR_WIDTH+1, zero-extended to 16 bits.
- Pointers wrap from depth-1 to 0 without loss of ordering.
- Sticky flags clear only on ti_rst.
- RAM is inferred as simple dual-port block RAM with a registered read. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles. ti_out_available goes 0→1→2. Two pops return 0x2211, then 0x4433, each 1 cycle after its en. Count returns to 0; flags stay 0.
- Byte 0xAB then a flush pulse: one word 0x00AB. Byte 0xCD with flush in the same cycle in EMPTY: word 0x00CD. Flush alone in EMPTY: count unchanged.
- MEM_ADDR_WIDTH=2 (depth 4): push 5 words. Count saturates at 4, overflow=1, and pops return the first 4 words in order. Then push a word and pop in the same cycle while full: count stays 4, no new overflow event, and ordering is preserved.
- Pop on an empty FIFO: underflow=1, ti_out_data holds its previous value, count stays 0. Then push 0x5A,0xA5: count=1, pop returns 0xA55A, and underflow stays 1.
- Wrap with depth 4: 10 rounds of 3 pushes and 3 pops with incrementing data. Every word is returned in order and count ends at 0.
- Reset mid-stream: load 2 words plus a half byte, then assert ti_rst for 1 cycle. Count=0, data=0, flags=0. A subsequent byte pair packs correctly with no stale half byte.
